matrix_read_sequencer: RTL and testbench

Row-major read sequencer that drains a NUM_ROWS x NUM_COLS matrix buffer (feature or weight tile) from a synchronous single-port SRAM and streams it to the GCN datapath over a valid/ready interface. It is the consumer-side counterpart of the wrap-around index counters that fill these buffers. It generates addresses, absorbs the 1-cycle SRAM read latency with a 2-entry skid FIFO, tags each element with its row/column and last flag, and pulses done at the end of the transfer.

---
 rtl/gcn_pkg.sv | 48 ++++
 rtl/read_skid_fifo.sv | 86 ++++++++
 rtl/matrix_read_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_matrix_read_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// -----------------------------------------------------------------------------
// gcn_pkg
// Shared definitions for the GCN tile read path:
//   - sequencer state encoding (IDLE / READ / DRAIN / DONE)
//   - num_elems(): element count of a NUM_ROWS x NUM_COLS tile, usable in
//     localparam expressions
//   - GCN_FIFO_ENTRY_T(): builds the packed skid-FIFO entry
//     {data, row, col, last} for a given set of widths. SystemVerilog packages
//     cannot carry width-parameterized types, so the entry layout is kept here
//     as a macro and instantiated inside the module that knows the widths.
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef GCN_PKG_SV
`define GCN_PKG_SV

`define GCN_FIFO_ENTRY_T(DW, RW, CW) \
   struct packed { \
      logic [(DW)-1:0] data; \
      logic [(RW)-1:0] row; \
      logic [(CW)-1:0] col; \
      logic            last; \
   }

package gcn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   // Total number of elements in a row-major tile.
   function automatic int unsigned num_elems(input int unsigned rows,
                                             input int unsigned cols);
      return rows * cols;
   endfunction

   // Width of one FIFO entry for the given field widths.
   function automatic int unsigned fifo_entry_width(input int unsigned dw,
                                                    input int unsigned rw,
                                                    input int unsigned cw);
      return dw + rw + cw + 1;
   endfunction

endpackage

`endif

// File: rtl/read_skid_fifo.sv
// -----------------------------------------------------------------------------
// read_skid_fifo
// Two-entry synchronous FIFO that absorbs the one-cycle SRAM read latency in
// front of a valid/ready consumer. Push and pop may happen in the same cycle
// at any occupancy (a push into a full FIFO is accepted only when the head is
// popped in that same cycle).
//
// Ports:
//   clk      in   clock, rising edge
//   srst_i   in   synchronous active-high reset; empties the FIFO
//   push_i   in   write din_i at the tail
//   din_i    in   entry to write
//   pop_i    in   remove the head entry (ignored when empty)
//   dout_o   out  head entry
//   valid_o  out  FIFO not empty
//   count_o  out  current occupancy (0..2)
// -----------------------------------------------------------------------------
module read_skid_fifo #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             srst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             valid_o,
   output logic [1:0]       count_o
);

   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] count_q;
   logic [1:0] count_d;
   logic       push_ok;
   logic       pop_ok;

   assign pop_ok  = pop_i & (count_q != 2'd0);
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign push_ok = push_i & ((count_q != 2'd2) | pop_ok);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic [WIDTH-1:0] data_q;

         always_ff @(posedge clk) begin
            if (srst_i) begin
               data_q <= '0;
            end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
               data_q <= din_i;
            end
         end
      end
   endgenerate

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign dout_o  = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
   assign valid_o = (count_q != 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/matrix_read_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_read_sequencer
// Drains a NUM_ROWS x NUM_COLS tile from a synchronous single-port SRAM in
// row-major order and streams it over valid/ready, tagging every element with
// its row, column and a last flag. A two-entry skid FIFO hides the one-cycle
// read latency; reads are throttled by a credit check so the FIFO can never
// overflow and no returned word is lost. done pulses for one cycle after the
// last element is accepted.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a transfer (only looked at in IDLE)
//   busy         out  transfer in progress (READ or DRAIN)
//   done         out  one-cycle pulse after the final handshake
//   mem_rd_en    out  SRAM read strobe
//   mem_rd_addr  out  SRAM read address
//   mem_rd_data  in   SRAM read data, valid one cycle after mem_rd_en
//   out_valid    out  element available
//   out_ready    in   downstream accepts the element
//   out_data     out  element value
//   out_row      out  element row index
//   out_col      out  element column index
//   out_last     out  final element of the tile
// -----------------------------------------------------------------------------
module matrix_read_sequencer
   import gcn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_ROWS   = 6,
   parameter int unsigned NUM_COLS   = 3,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ROW_WIDTH  = 3,
   parameter int unsigned COL_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ROW_WIDTH-1:0]  out_row,
   output logic [COL_WIDTH-1:0]  out_col,
   output logic                  out_last
);

   localparam int unsigned N = num_elems(NUM_ROWS, NUM_COLS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);
   localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(NUM_COLS - 1);
   localparam int unsigned ENTRY_W = fifo_entry_width(DATA_WIDTH, ROW_WIDTH, COL_WIDTH);

   typedef `GCN_FIFO_ENTRY_T(DATA_WIDTH, ROW_WIDTH, COL_WIDTH) entry_t;

   // ---------------------------------------------------------------------
   // State and counters
   // ---------------------------------------------------------------------
   seq_state_e            state_q;
   seq_state_e            state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [ROW_WIDTH-1:0]  row_q;
   logic [ROW_WIDTH-1:0]  row_d;
   logic [COL_WIDTH-1:0]  col_q;
   logic [COL_WIDTH-1:0]  col_d;

   // Tags of the read in flight; they meet the SRAM data one cycle later.
   logic                  inflight_q;
   logic [ROW_WIDTH-1:0]  tag_row_q;
   logic [COL_WIDTH-1:0]  tag_col_q;
   logic                  tag_last_q;

   logic                  issue;
   logic                  pop;
   logic                  credit_ok;
   logic                  is_last_addr;
   logic                  fifo_valid;
   logic [1:0]            fifo_count;
   entry_t                push_entry;
   entry_t                head_entry;
   logic [ENTRY_W-1:0]    head_bits;

   assign pop          = fifo_valid & out_ready;
   assign is_last_addr = (addr_q == LAST_ADDR);

   // Words already owed to the FIFO (stored + in flight) minus the one
   // leaving this cycle must stay below the depth of 2 before a new read.
   assign credit_ok = (({1'b0, fifo_count} + {2'b00, inflight_q}) <
                       (3'd2 + {2'b00, pop}));

   // ---------------------------------------------------------------------
   // Next-state / read issue
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      col_d   = col_q;
      issue   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               addr_d  = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end

         READ: begin
            if (credit_ok) begin
               issue  = 1'b1;
               addr_d = addr_q + 1'b1;
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (is_last_addr) begin
                  state_d = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (pop && head_entry.last) begin
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         inflight_q <= 1'b0;
         tag_row_q  <= '0;
         tag_col_q  <= '0;
         tag_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         row_q      <= row_d;
         col_q      <= col_d;
         inflight_q <= issue;
         if (issue) begin
            tag_row_q  <= row_q;
            tag_col_q  <= col_q;
            tag_last_q <= is_last_addr;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Skid FIFO: returning SRAM word is paired with its registered tags
   // ---------------------------------------------------------------------
   always_comb begin
      push_entry      = '0;
      push_entry.data = mem_rd_data;
      push_entry.row  = tag_row_q;
      push_entry.col  = tag_col_q;
      push_entry.last = tag_last_q;
   end

   read_skid_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .srst_i  (reset),
      .push_i  (inflight_q),
      .din_i   (push_entry),
      .pop_i   (pop),
      .dout_o  (head_bits),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign head_entry = entry_t'(head_bits);

   // ---------------------------------------------------------------------
   // Outputs. Element fields are forced to zero while nothing is valid so a
   // stale FIFO slot never shows up on the bus; the head is stable while
   // stalled because it only moves on a pop.
   // ---------------------------------------------------------------------
   assign busy        = (state_q == READ) || (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr_q;
   assign out_valid   = fifo_valid;
   assign out_data    = fifo_valid ? head_entry.data : '0;
   assign out_row     = fifo_valid ? head_entry.row  : '0;
   assign out_col     = fifo_valid ? head_entry.col  : '0;
   assign out_last    = fifo_valid & head_entry.last;

endmodule

// File: tb/tb_matrix_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_read_sequencer
// Directed bench for matrix_read_sequencer: a default 6x3 instance (A) and a
// 1x1 instance (B), each fed by a small synchronous SRAM model.
// -----------------------------------------------------------------------------
module tb_matrix_read_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A: 6 x 3 ----------------
   logic        a_reset, a_start, a_busy, a_done, a_rd_en;
   logic [4:0]  a_rd_addr;
   logic [15:0] a_rd_data;
   logic        a_valid, a_ready, a_last;
   logic [15:0] a_data;
   logic [2:0]  a_row;
   logic [1:0]  a_col;
   logic [15:0] mem_a [0:31];

   matrix_read_sequencer #(
      .DATA_WIDTH(16), .NUM_ROWS(6), .NUM_COLS(3),
      .ADDR_WIDTH(5), .ROW_WIDTH(3), .COL_WIDTH(2)
   ) dut_a (
      .clk(clk), .reset(a_reset), .start(a_start), .busy(a_busy), .done(a_done),
      .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr), .mem_rd_data(a_rd_data),
      .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data),
      .out_row(a_row), .out_col(a_col), .out_last(a_last)
   );

   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
   end

   // ---------------- instance B: 1 x 1 ----------------
   logic        b_reset, b_start, b_busy, b_done, b_rd_en;
   logic [0:0]  b_rd_addr;
   logic [15:0] b_rd_data;
   logic        b_valid, b_ready, b_last;
   logic [15:0] b_data;
   logic [0:0]  b_row;
   logic [0:0]  b_col;

   matrix_read_sequencer #(
      .DATA_WIDTH(16), .NUM_ROWS(1), .NUM_COLS(1),
      .ADDR_WIDTH(1), .ROW_WIDTH(1), .COL_WIDTH(1)
   ) dut_b (
      .clk(clk), .reset(b_reset), .start(b_start), .busy(b_busy), .done(b_done),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(b_rd_data),
      .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
      .out_row(b_row), .out_col(b_col), .out_last(b_last)
   );

   always @(posedge clk) begin
      if (b_rd_en) b_rd_data <= (b_rd_addr == 1'b0) ? 16'h5A5A : 16'hDEAD;
   end

   // ---------------- scoreboard state for A ----------------
   logic        mon_a = 1'b0;
   int          rd_exp;
   int          pop_exp;
   logic        held_v;
   logic [31:0] held_elem;

   function automatic logic ready_for(input int mode, input int c);
      case (mode)
         1:       return (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);
         2:       return (c > 10);
         default: return 1'b1;
      endcase
   endfunction

   // Called once per cycle at the falling edge.
   task automatic monitor_a();
      if (!mon_a) return;
      if (a_rd_en) begin
         check_eq("rd_addr", 32'(a_rd_addr), rd_exp);
         rd_exp++;
      end
      if (held_v) begin
         check_eq("hold_valid", 32'(a_valid), 1);
         check_eq("hold_elem", 32'({a_data, a_row, a_col, a_last}), held_elem);
      end
      if (a_valid && a_ready) begin
         check_eq("elem_data", 32'(a_data), 32'h0000A000 + pop_exp);
         check_eq("elem_row", 32'(a_row), pop_exp / 3);
         check_eq("elem_col", 32'(a_col), pop_exp % 3);
         check_eq("elem_last", 32'(a_last), (pop_exp == 17) ? 1 : 0);
         $display("ELEM idx=%0d data=%h row=%0d col=%0d last=%0d",
                  pop_exp, a_data, a_row, a_col, a_last);
         pop_exp++;
      end
      if (a_rd_en) begin
         check_eq("outstanding_le2", 32'((rd_exp - pop_exp) <= 2), 1);
      end
      held_v    = a_valid && !a_ready;
      held_elem = 32'({a_data, a_row, a_col, a_last});
   endtask

   // One transfer on A. mode: 0 ready=1, 1 ready 1,0,0,1, 2 ready=0 for
   // cycles 1..10, 3 start re-pulsed at cycle 5, 4 reset at cycle 7.
   task automatic run_a(input int mode, output int done_cyc);
      int c;
      int limit;
      limit = (mode == 4) ? 30 : 400;
      @(posedge clk); #1;
      a_reset = 1'b0;
      a_start = 1'b1;
      a_ready = ready_for(mode, 0);
      rd_exp  = 0;
      pop_exp = 0;
      held_v  = 1'b0;
      mon_a   = 1'b1;
      @(posedge clk); #1;
      a_start  = 1'b0;
      a_ready  = ready_for(mode, 1);
      c        = 1;
      done_cyc = -1;
      while (done_cyc < 0 && c < limit) begin
         @(negedge clk);
         monitor_a();
         if (c == 1) begin
            check_eq("c1_busy", 32'(a_busy), 1);
            check_eq("c1_rd_en", 32'(a_rd_en), 1);
            check_eq("c1_addr", 32'(a_rd_addr), 0);
         end
         if (mode == 0 && c == 2) check_eq("c2_valid", 32'(a_valid), 0);
         if (mode == 0 && c == 3) check_eq("c3_valid", 32'(a_valid), 1);
         if (mode == 2 && c == 10) begin
            check_eq("stall_reads", rd_exp, 2);
            check_eq("stall_valid", 32'(a_valid), 1);
         end
         if (mode == 4 && c == 8) begin
            check_eq("rst_outs", 32'({a_busy, a_done, a_rd_en, a_rd_addr, a_valid,
                                      a_data, a_row, a_col, a_last}), 0);
         end
         if (a_done) begin
            done_cyc = c;
            check_eq("busy_at_done", 32'(a_busy), 0);
         end
         @(posedge clk); #1;
         c++;
         a_ready = ready_for(mode, c);
         a_start = (mode == 3 && c == 5);
         a_reset = (mode == 4 && c == 7);
         if (mode == 4 && c == 8) mon_a = 1'b0;
      end
      mon_a = 1'b0;
      if (mode != 4) begin
         check_eq("elem_count", pop_exp, 18);
         @(negedge clk);
         check_eq("done_pulse_end", 32'({a_done, a_busy}), 0);
      end
   endtask

   int dc;

   initial begin
      for (int i = 0; i < 32; i++) mem_a[i] = 16'hA000 + 16'(i);
      a_reset = 1'b1; a_start = 1'b0; a_ready = 1'b1;
      b_reset = 1'b1; b_start = 1'b0; b_ready = 1'b1;
      held_v = 1'b0; held_elem = '0; rd_exp = 0; pop_exp = 0;
      repeat (3) @(posedge clk);
      #1;
      a_reset = 1'b0;
      b_reset = 1'b0;
      @(negedge clk);
      check_eq("reset_outs_a", 32'({a_busy, a_done, a_rd_en, a_rd_addr, a_valid,
                                    a_data, a_row, a_col, a_last}), 0);
      check_eq("reset_outs_b", 32'({b_busy, b_done, b_rd_en, b_rd_addr, b_valid,
                                    b_data, b_row, b_col, b_last}), 0);

      run_a(0, dc); check_eq("done_cycle_ready1", dc, 21);
      run_a(1, dc); check_eq("done_seen_toggle", 32'(dc > 0), 1);
      run_a(2, dc); check_eq("done_cycle_stall10", dc, 29);
      run_a(3, dc); check_eq("done_cycle_restart_ignored", dc, 21);
      run_a(0, dc); check_eq("done_cycle_second_start", dc, 21);
      run_a(4, dc); check_eq("no_done_after_reset", dc, -1);
      run_a(0, dc); check_eq("done_cycle_after_reset", dc, 21);

      // 1x1 instance
      @(posedge clk); #1; b_start = 1'b1;          // cycle 0
      @(posedge clk); #1; b_start = 1'b0;          // cycle 1
      @(negedge clk);
      check_eq("b_c1_rd", 32'({b_busy, b_rd_en, b_rd_addr}), 32'b110);
      @(posedge clk); #1;                           // cycle 2
      @(negedge clk);
      check_eq("b_c2", 32'({b_valid, b_rd_en}), 0);
      @(posedge clk); #1;                           // cycle 3
      @(negedge clk);
      check_eq("b_c3_valid", 32'(b_valid), 1);
      check_eq("b_c3_elem", 32'({b_data, b_row, b_col, b_last}), 32'({16'h5A5A, 3'b001}));
      $display("ELEM b data=%h row=%0d col=%0d last=%0d", b_data, b_row, b_col, b_last);
      @(posedge clk); #1;                           // cycle 4
      @(negedge clk);
      check_eq("b_c4_done", 32'({b_done, b_busy, b_valid, b_rd_en}), 32'b1000);
      @(posedge clk); #1;                           // cycle 5
      @(negedge clk);
      check_eq("b_c5_idle", 32'({b_done, b_busy}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
